// File: rtl/msg_queue_arbiter_pkg.sv
// Shared types: the Bus command/response encodings and the arbiter FSM state enum.
package Bus;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } Cmd;

    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        ERR  = 2'd2
    } Resp;
endpackage

package Msg_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } Msg_arb_state_t;
endpackage

// File: rtl/msg_queue_arbiter_if.sv
// Requester-side and queue-side bus bundle for msg_queue_arbiter; master is the arbiter's view.
interface msg_queue_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    Bus::Cmd                 req_MCmd  [NREQ];
    logic [ADDR_WIDTH-1:0]   req_MAddr [NREQ];
    logic [DATA_WIDTH-1:0]   req_MData [NREQ];
    logic [NREQ-1:0]         req_MDataValid;
    logic [NREQ-1:0]         req_SCmdAccept;
    logic [NREQ-1:0]         req_SDataAccept;
    Bus::Resp                req_SResp [NREQ];

    Bus::Cmd                 m_MCmd;
    logic [ADDR_WIDTH-1:0]   m_MAddr;
    logic [DATA_WIDTH-1:0]   m_MData;
    logic                    m_MDataValid;
    logic                    m_SCmdAccept;
    logic                    m_SDataAccept;
    Bus::Resp                m_SResp;

    logic [$clog2(NREQ)-1:0] owner;
    logic                    busy;

    modport master (
        input  req_MCmd, req_MAddr, req_MData, req_MDataValid,
        input  m_SCmdAccept, m_SDataAccept, m_SResp,
        output req_SCmdAccept, req_SDataAccept, req_SResp,
        output m_MCmd, m_MAddr, m_MData, m_MDataValid,
        output owner, busy
    );

    modport slave (
        output req_MCmd, req_MAddr, req_MData, req_MDataValid,
        output m_SCmdAccept, m_SDataAccept, m_SResp,
        input  req_SCmdAccept, req_SDataAccept, req_SResp,
        input  m_MCmd, m_MAddr, m_MData, m_MDataValid,
        input  owner, busy
    );
endinterface

// File: rtl/msg_queue_arbiter_rr_picker.sv
// Combinational winner selection: round-robin from last_grant+1, or lowest index first
// when MSG_QUEUE_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            grant_valid,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IW-1:0]   grant_idx
);
    always_comb begin
        int start;
        int cand;
        grant_valid  = 1'b0;
        grant_onehot = '0;
        grant_idx    = '0;
        cand         = 0;
`ifdef MSG_QUEUE_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = (int'(last_grant) + 1) % NREQ;
`endif
        for (int k = 0; k < NREQ; k++) begin
            cand = (start + k) % NREQ;
            if (!grant_valid && req[cand]) begin
                grant_valid        = 1'b1;
                grant_idx          = IW'(cand);
                grant_onehot[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/msg_queue_arbiter.sv
// N-to-1 command arbiter in front of a message queue writer port. Round-robin by default;
// MSG_QUEUE_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module msg_queue_arbiter
    import Msg_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic                clk,
    input logic                rst_n,
    msg_queue_arbiter_if.master bus
);
    localparam int OWW = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CMD  = CMD;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]      state_reg, state_next;
    logic [OWW-1:0]  owner_reg, owner_next;
    logic [OWW-1:0]  last_grant_reg;
    logic [NREQ-1:0] req_vec;
    logic [NREQ-1:0] pick_onehot;
    logic [NREQ-1:0] sel;
    logic [NREQ-1:0] scmd_acc;
    logic [NREQ-1:0] sdata_acc;
    logic [OWW-1:0]  pick_idx;
    logic            pick_valid;
    logic            in_cmd;
    logic            routed;
    logic            owner_active;
    logic            cmd_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_vec[gi] = (bus.req_MCmd[gi] != Bus::IDLE);
        end
    endgenerate

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req          (req_vec),
        .last_grant   (last_grant_reg),
        .grant_valid  (pick_valid),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx)
    );

    assign in_cmd       = (state_reg == ST_CMD);
    assign routed       = (state_reg != ST_IDLE);
    assign owner_active = (bus.req_MCmd[owner_reg] != Bus::IDLE);
    assign cmd_accept   = in_cmd && owner_active && bus.m_SCmdAccept;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_idx;
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                // A withdrawn command abandons the grant without touching the pointer.
                if (!owner_active) begin
                    state_next = ST_IDLE;
                end else if (bus.m_SCmdAccept) begin
                    state_next = (bus.m_SResp != Bus::NULL) ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.m_SResp != Bus::NULL) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

`ifdef MSG_QUEUE_ARB_FIXED_PRIO_EN
    assign last_grant_reg = '0;
`else
    // Reset to NREQ-1 so the first search after reset starts at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= OWW'(NREQ - 1);
        end else if (cmd_accept) begin
            last_grant_reg <= owner_reg;
        end
    end
`endif

    assign bus.m_MCmd       = in_cmd ? bus.req_MCmd[owner_reg] : Bus::IDLE;
    assign bus.m_MAddr      = in_cmd ? bus.req_MAddr[owner_reg] : {ADDR_WIDTH{1'b0}};
    assign bus.m_MData      = in_cmd ? bus.req_MData[owner_reg] : {DATA_WIDTH{1'b0}};
    assign bus.m_MDataValid = in_cmd && bus.req_MDataValid[owner_reg];

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_route
            assign sel[gi]       = routed && (owner_reg == OWW'(gi));
            assign scmd_acc[gi]  = sel[gi] && bus.m_SCmdAccept && (!in_cmd || owner_active);
            assign sdata_acc[gi] = sel[gi] && bus.m_SDataAccept;
            assign bus.req_SResp[gi] = sel[gi] ? bus.m_SResp : Bus::NULL;
        end
    endgenerate

    assign bus.req_SCmdAccept  = scmd_acc;
    assign bus.req_SDataAccept = sdata_acc;
    assign bus.owner           = owner_reg;
    assign bus.busy            = routed;

    // The one-hot grant is only for observability; the index drives the owner register.
    logic unused_onehot;
    assign unused_onehot = ^pick_onehot;
endmodule

// File: tb/tb_msg_queue_arbiter.sv
// Scoreboard bench for msg_queue_arbiter: directed scenarios push expected accepts/responses,
// two monitors pop and compare whenever the DUT forwards an accept or a response.
module tb_msg_queue_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msg_queue_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    msg_queue_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           idx;
        Bus::Cmd      cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_cmd_t;

    typedef struct {
        int       idx;
        Bus::Resp resp;
    } exp_resp_t;

    exp_cmd_t  cmd_q[$];
    exp_resp_t resp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, Bus::Cmd c, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.req_MCmd[i]       = c;
        bus.req_MAddr[i]      = a;
        bus.req_MData[i]      = d;
        bus.req_MDataValid[i] = (c == Bus::WR);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, Bus::IDLE, '0, '0);
    endtask

    task automatic slave(logic acc, Bus::Resp r);
        bus.m_SCmdAccept  = acc;
        bus.m_SDataAccept = acc;
        bus.m_SResp       = r;
    endtask

    task automatic push_cmd(int i, Bus::Cmd c, logic [AW-1:0] a, logic [DW-1:0] d);
        exp_cmd_t e;
        e.idx = i; e.cmd = c; e.addr = a; e.data = d;
        cmd_q.push_back(e);
    endtask

    task automatic push_resp(int i, Bus::Resp r);
        exp_resp_t e;
        e.idx = i; e.resp = r;
        resp_q.push_back(e);
    endtask

    task automatic all_request();
        for (int i = 0; i < NREQ; i++)
            set_req(i, (i % 2 == 1) ? Bus::RD : Bus::WR, 32'h1000 + i, 32'hD000_0000 + i);
    endtask

    // Command-accept monitor
    initial begin
        forever begin
            exp_cmd_t e;
            @(negedge clk);
            if (rst_n && bus.m_MCmd != Bus::IDLE && bus.m_SCmdAccept) begin
                $display("accept: owner=%0d cmd=%0d addr=0x%0h data=0x%0h",
                         bus.owner, bus.m_MCmd, bus.m_MAddr, bus.m_MData);
                if (cmd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_accept: owner %0d accepted, none expected", bus.owner);
                end else begin
                    e = cmd_q.pop_front();
                    check("acc_owner", 64'(bus.owner), 64'(e.idx));
                    check("acc_cmd",   64'(bus.m_MCmd), 64'(e.cmd));
                    check("acc_addr",  64'(bus.m_MAddr), 64'(e.addr));
                    check("acc_data",  64'(bus.m_MData), 64'(e.data));
                    check("acc_route", 64'(bus.req_SCmdAccept), 64'(1) << e.idx);
                end
            end
        end
    end

    // Response-routing monitor
    initial begin
        forever begin
            exp_resp_t e;
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_SResp[i] != Bus::NULL) begin
                    $display("response: req=%0d resp=%0d", i, bus.req_SResp[i]);
                    if (resp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_resp: req %0d got resp %0d", i, bus.req_SResp[i]);
                    end else begin
                        e = resp_q.pop_front();
                        check("resp_idx",  64'(i), 64'(e.idx));
                        check("resp_code", 64'(bus.req_SResp[i]), 64'(e.resp));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MSG_QUEUE_ARB_FIXED_PRIO_EN
        int order[5] = '{0, 0, 0, 0, 0};
        int after_withdraw = 0;
`else
        int order[5] = '{0, 1, 2, 3, 0};
        int after_withdraw = 1;
`endif
        clear_reqs();
        slave(1'b1, Bus::DVA);
        rst_n = 1'b0;

        // Reset state, with slave driving accept/DVA to prove outputs are gated
        step();
        step();
        @(negedge clk);
        check("rst_busy",  64'(bus.busy), 64'(0));
        check("rst_owner", 64'(bus.owner), 64'(0));
        check("rst_mcmd",  64'(bus.m_MCmd), 64'(Bus::IDLE));
        check("rst_sacc",  64'(bus.req_SCmdAccept), 64'(0));
        check("rst_dacc",  64'(bus.req_SDataAccept), 64'(0));
        step();
        rst_n = 1'b1;
        slave(1'b0, Bus::NULL);
        step();

        // Single requester 2, accept + DVA in the same cycle
        set_req(2, Bus::WR, 32'h20, 32'hA5);
        slave(1'b1, Bus::DVA);
        push_cmd(2, Bus::WR, 32'h20, 32'hA5);
        push_resp(2, Bus::DVA);
        @(negedge clk);
        check("t1_arb_latency", 64'(bus.m_MCmd), 64'(Bus::IDLE));
        check("t1_idle_busy",   64'(bus.busy), 64'(0));
        step();
        @(negedge clk);
        check("t1_mcmd_wr", 64'(bus.m_MCmd), 64'(Bus::WR));
        step();
        clear_reqs();
        slave(1'b0, Bus::NULL);
        @(negedge clk);
        check("t1_busy_done", 64'(bus.busy), 64'(0));

        // All four request continuously from reset; slave always accepts
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        all_request();
        slave(1'b1, Bus::DVA);
        for (int g = 0; g < 5; g++) begin
            int k;
            k = order[g];
            push_cmd(k, (k % 2 == 1) ? Bus::RD : Bus::WR, 32'h1000 + k, 32'hD000_0000 + k);
            push_resp(k, Bus::DVA);
        end
        for (int c = 0; c < 10; c++) step();
        clear_reqs();
        slave(1'b0, Bus::NULL);
        step();

        // Slave stalls accept for 5 cycles while requester 3 also waits
        set_req(1, Bus::WR, 32'h11, 32'h1111);
        set_req(3, Bus::RD, 32'h33, 32'h0);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_owner_held", 64'(bus.owner), 64'(1));
            check("t3_mdata_hold", 64'(bus.m_MData), 64'(32'h1111));
            check("t3_mcmd_hold",  64'(bus.m_MCmd), 64'(Bus::WR));
            step();
        end
        push_cmd(1, Bus::WR, 32'h11, 32'h1111);
        push_resp(1, Bus::DVA);
        push_cmd(3, Bus::RD, 32'h33, 32'h0);
        push_resp(3, Bus::DVA);
        slave(1'b1, Bus::DVA);
        step();
        set_req(1, Bus::IDLE, '0, '0);
        step();
        @(negedge clk);
        check("t3_owner3", 64'(bus.owner), 64'(3));
        step();
        clear_reqs();
        slave(1'b0, Bus::NULL);
        step();

        // Accept without response; DVA three cycles later
        set_req(0, Bus::WR, 32'h40, 32'h4444);
        slave(1'b1, Bus::NULL);
        push_cmd(0, Bus::WR, 32'h40, 32'h4444);
        step();
        step();
        clear_reqs();
        slave(1'b0, Bus::NULL);
        @(negedge clk);
        check("t4_resp_busy", 64'(bus.busy), 64'(1));
        check("t4_resp_mcmd", 64'(bus.m_MCmd), 64'(Bus::IDLE));
        step();
        @(negedge clk);
        check("t4_resp_wait", 64'(bus.busy), 64'(1));
        step();
        slave(1'b0, Bus::DVA);
        push_resp(0, Bus::DVA);
        @(negedge clk);
        check("t4_resp_owner", 64'(bus.owner), 64'(0));
        step();
        slave(1'b0, Bus::NULL);
        @(negedge clk);
        check("t4_idle", 64'(bus.busy), 64'(0));
        step();

        // Reset pulse while in RESP
        set_req(1, Bus::WR, 32'h50, 32'h5555);
        slave(1'b1, Bus::NULL);
        push_cmd(1, Bus::WR, 32'h50, 32'h5555);
        step();
        step();
        clear_reqs();
        check("t5_in_resp", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        slave(1'b1, Bus::DVA);
        #1;
        check("t5_rst_busy",  64'(bus.busy), 64'(0));
        check("t5_rst_owner", 64'(bus.owner), 64'(0));
        check("t5_rst_mcmd",  64'(bus.m_MCmd), 64'(Bus::IDLE));
        check("t5_rst_sacc",  64'(bus.req_SCmdAccept), 64'(0));
        check("t5_rst_dacc",  64'(bus.req_SDataAccept), 64'(0));
        check("t5_rst_resp1", 64'(bus.req_SResp[1]), 64'(Bus::NULL));
        step();
        rst_n = 1'b1;
        all_request();
        push_cmd(0, Bus::WR, 32'h1000, 32'hD000_0000);
        push_resp(0, Bus::DVA);
        step();
        step();
        clear_reqs();
        slave(1'b0, Bus::NULL);
        step();

        // Owner withdraws in CMD: no accept forwarded, pointer untouched
        set_req(2, Bus::WR, 32'h60, 32'h6666);
        step();
        clear_reqs();
        slave(1'b1, Bus::NULL);
        @(negedge clk);
        check("t6_mcmd_idle", 64'(bus.m_MCmd), 64'(Bus::IDLE));
        check("t6_no_accept", 64'(bus.req_SCmdAccept), 64'(0));
        step();
        check("t6_back_idle", 64'(bus.busy), 64'(0));
        all_request();
        slave(1'b1, Bus::DVA);
        push_cmd(after_withdraw, (after_withdraw % 2 == 1) ? Bus::RD : Bus::WR,
                 32'h1000 + after_withdraw, 32'hD000_0000 + after_withdraw);
        push_resp(after_withdraw, Bus::DVA);
        step();
        step();
        clear_reqs();
        slave(1'b0, Bus::NULL);
        step();
        step();

        check("cmd_q_drained",  64'(cmd_q.size()), 64'(0));
        check("resp_q_drained", 64'(resp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
